// File: rtl/soc_pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// Optional retry limit: SOC_PLL_SUP_RETRY_LIMIT_EN (see soc_pll_supervisor).
package soc_pll_sup_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned LOSS_CNT_W = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'hFF;

    typedef enum logic [STATE_W-1:0] {
        StResetPll = 3'd0,
        StWaitLock = 3'd1,
        StFilter   = 3'd2,
        StRelease  = 3'd3,
        StRun      = 3'd4,
        StFailed   = 3'd5
    } sup_state_e;

endpackage

// File: rtl/soc_pll_sup_sync.sv
// Two-flop synchroniser for the asynchronous PLL locked indication.
module soc_pll_sup_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/soc_pll_supervisor.sv
// PLL lock supervisor: PLL reset, lock qualification, staggered channel reset release.
// Define SOC_PLL_SUP_RETRY_LIMIT_EN to enter FAILED after MAX_RETRIES failed attempts.
module soc_pll_supervisor
    import soc_pll_sup_pkg::*;
#(
    parameter int unsigned NUM_CH              = 4,
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_FILTER_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned STAGGER_CYCLES      = 8,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  force_relock,
    output logic                  pll_rst,
    output logic [NUM_CH-1:0]     ch_rst_n,
    output logic                  sup_locked,
    output logic                  failed,
    output logic [STATE_W-1:0]    sup_state,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int unsigned HOLD_W  = $clog2(RST_HOLD_CYCLES) + 1;
    localparam int unsigned FILT_W  = $clog2(LOCK_FILTER_CYCLES) + 1;
    localparam int unsigned TO_W    = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int unsigned STAG_W  = $clog2(STAGGER_CYCLES) + 1;
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES) + 1;
    localparam int unsigned CH_W    = 5;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]   CH_ALL    = CH_W'(NUM_CH);

    logic lk_s;

    soc_pll_sup_sync u_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    sup_state_e                state_q, state_d;
    logic [HOLD_W-1:0]         hold_q, hold_d;
    logic [FILT_W-1:0]         filt_q, filt_d;
    logic [TO_W-1:0]           to_q, to_d;
    logic [STAG_W-1:0]         stag_q, stag_d;
    logic [CH_W-1:0]           ch_idx_q, ch_idx_d;
    logic [RETRY_W-1:0]        retry_q, retry_d;
    logic [LOSS_CNT_W-1:0]     loss_q, loss_d;
    logic [NUM_CH-1:0]         ch_q, ch_d;
    logic                      pll_rst_q, pll_rst_d;
    logic                      locked_q, locked_d;
    logic                      lost;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        filt_d   = filt_q;
        to_d     = to_q;
        stag_d   = stag_q;
        ch_idx_d = ch_idx_q;
        retry_d  = retry_q;
        loss_d   = loss_q;
        ch_d     = ch_q;
        lost     = 1'b0;

        case (state_q)
            StResetPll: begin
                ch_d = '0;
                if (hold_q == HOLD_LAST) begin
                    state_d = StWaitLock;
                    to_d    = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StWaitLock, StFilter: begin
                to_d = to_q + 1'b1;
                if (to_q == TO_LAST) begin
                    hold_d = '0;
`ifdef SOC_PLL_SUP_RETRY_LIMIT_EN
                    if (retry_q == RETRY_W'(MAX_RETRIES)) begin
                        state_d = StFailed;
                    end else begin
                        state_d = StResetPll;
                        retry_d = retry_q + 1'b1;
                    end
`else
                    state_d = StResetPll;
                    retry_d = (&retry_q) ? retry_q : retry_q + 1'b1;
`endif
                end else if (state_q == StWaitLock) begin
                    if (lk_s) begin
                        state_d = StFilter;
                        filt_d  = '0;
                    end
                end else if (!lk_s) begin
                    state_d = StWaitLock;
                end else if (filt_q == FILT_LAST) begin
                    // Channel 0 comes out of reset on the same edge RELEASE is entered.
                    state_d  = StRelease;
                    ch_d     = NUM_CH'(1);
                    stag_d   = '0;
                    ch_idx_d = CH_W'(1);
                end else begin
                    filt_d = filt_q + 1'b1;
                end
            end
            StRelease: begin
                if (!lk_s) begin
                    lost = 1'b1;
                end else if (ch_idx_q >= CH_ALL) begin
                    state_d = StRun;
                    retry_d = '0;
                end else if (stag_q == STAG_LAST) begin
                    ch_d     = ch_q | (NUM_CH'(1) << ch_idx_q);
                    stag_d   = '0;
                    ch_idx_d = ch_idx_q + 1'b1;
                    if (ch_idx_q == CH_LAST) begin
                        state_d = StRun;
                        retry_d = '0;
                    end
                end else begin
                    stag_d = stag_q + 1'b1;
                end
            end
            StRun: begin
                if (!lk_s) begin
                    lost = 1'b1;
                end
            end
            StFailed: begin
                ch_d = '0;
            end
            default: begin
                state_d = StResetPll;
                hold_d  = '0;
                ch_d    = '0;
            end
        endcase

        if (lost) begin
            state_d = StResetPll;
            hold_d  = '0;
            ch_d    = '0;
            loss_d  = (loss_q == LOSS_CNT_MAX) ? loss_q : loss_q + 1'b1;
        end

        if (force_relock) begin
            state_d = StResetPll;
            hold_d  = '0;
            retry_d = '0;
            ch_d    = '0;
        end

        pll_rst_d = (state_d == StResetPll) || (state_d == StFailed);
        locked_d  = (state_d == StRun);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StResetPll;
            hold_q    <= '0;
            filt_q    <= '0;
            to_q      <= '0;
            stag_q    <= '0;
            ch_idx_q  <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            ch_q      <= '0;
            pll_rst_q <= 1'b1;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            filt_q    <= filt_d;
            to_q      <= to_d;
            stag_q    <= stag_d;
            ch_idx_q  <= ch_idx_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            ch_q      <= ch_d;
            pll_rst_q <= pll_rst_d;
            locked_q  <= locked_d;
        end
    end

`ifdef SOC_PLL_SUP_RETRY_LIMIT_EN
    logic failed_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            failed_q <= 1'b0;
        end else begin
            failed_q <= (state_d == StFailed);
        end
    end

    assign failed = failed_q;
`else
    assign failed = 1'b0;
`endif

    assign pll_rst       = pll_rst_q;
    assign ch_rst_n      = ch_q;
    assign sup_locked    = locked_q;
    assign sup_state     = state_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_soc_pll_supervisor.sv
// Directed bench for soc_pll_supervisor; honours SOC_PLL_SUP_RETRY_LIMIT_EN if defined.
module tb_soc_pll_supervisor;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic [3:0] ch_rst_n;
    logic       sup_locked;
    logic       failed;
    logic [2:0] sup_state;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;

    soc_pll_supervisor #(
        .NUM_CH              (4),
        .RST_HOLD_CYCLES     (4),
        .LOCK_FILTER_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .STAGGER_CYCLES      (2),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .force_relock  (force_relock),
        .pll_rst       (pll_rst),
        .ch_rst_n      (ch_rst_n),
        .sup_locked    (sup_locked),
        .failed        (failed),
        .sup_state     (sup_state),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Advance one edge and sample 1ns after it.
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        step_n(2);
        rst_n = 1'b1;
    endtask

    // Edges until pll_rst samples low, bounded at 50.
    task automatic wait_rst_fall(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (pll_rst && n < 50);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        pll_locked   = 1'b1;
        force_relock = 1'b0;
        step_n(3);
        checks++; if (pll_rst !== 1'b1) begin errors++;
            $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
        checks++; if (ch_rst_n !== 4'b0000) begin errors++;
            $display("FAIL reset_ch_rst_n got %b want 0000", ch_rst_n); end
        checks++; if (sup_locked !== 1'b0 || failed !== 1'b0) begin errors++;
            $display("FAIL reset_flags got %b%b want 00", sup_locked, failed); end
        checks++; if (sup_state !== 3'd0 || lock_loss_cnt !== 8'd0) begin errors++;
            $display("FAIL reset_state got %0d/%0d want 0/0", sup_state, lock_loss_cnt); end
    endtask

    task automatic test_clean_lock();
        int n;
        do_reset();
        wait_rst_fall(n);
        checks++; if (n !== 4) begin errors++;
            $display("FAIL clean_hold_len got %0d want 4", n); end
        step_n(10);
        pll_locked = 1'b1;
        step_n(2);
        checks++; if (sup_state !== 3'd1) begin errors++;
            $display("FAIL clean_sync_lat got %0d want 1", sup_state); end
        step();
        checks++; if (sup_state !== 3'd2) begin errors++;
            $display("FAIL clean_filter_entry got %0d want 2", sup_state); end
        step_n(7);
        checks++; if (sup_state !== 3'd2 || ch_rst_n !== 4'b0000) begin errors++;
            $display("FAIL clean_filter_end got %0d/%b want 2/0000", sup_state, ch_rst_n); end
        step();
        checks++; if (sup_state !== 3'd3 || ch_rst_n !== 4'b0001) begin errors++;
            $display("FAIL clean_rel0 got %0d/%b want 3/0001", sup_state, ch_rst_n); end
        step();
        checks++; if (ch_rst_n !== 4'b0001) begin errors++;
            $display("FAIL clean_rel0_hold got %b want 0001", ch_rst_n); end
        step();
        checks++; if (ch_rst_n !== 4'b0011) begin errors++;
            $display("FAIL clean_rel1 got %b want 0011", ch_rst_n); end
        step_n(2);
        checks++; if (ch_rst_n !== 4'b0111 || sup_locked !== 1'b0) begin errors++;
            $display("FAIL clean_rel2 got %b/%b want 0111/0", ch_rst_n, sup_locked); end
        step_n(2);
        checks++; if (ch_rst_n !== 4'b1111 || sup_state !== 3'd4 || sup_locked !== 1'b1)
            begin errors++;
            $display("FAIL clean_run got %b/%0d/%b want 1111/4/1", ch_rst_n, sup_state,
                     sup_locked); end
    endtask

    task automatic test_lock_loss();
        int n;
        pll_locked = 1'b0;
        step_n(2);
        checks++; if (ch_rst_n !== 4'b1111 || sup_state !== 3'd4) begin errors++;
            $display("FAIL loss_early got %b/%0d want 1111/4", ch_rst_n, sup_state); end
        step();
        checks++; if (ch_rst_n !== 4'b0000 || lock_loss_cnt !== 8'd1) begin errors++;
            $display("FAIL loss_ch got %b/%0d want 0000/1", ch_rst_n, lock_loss_cnt); end
        checks++; if (pll_rst !== 1'b1 || sup_state !== 3'd0 || sup_locked !== 1'b0)
            begin errors++;
            $display("FAIL loss_pll got %b/%0d/%b want 1/0/0", pll_rst, sup_state,
                     sup_locked); end
        wait_rst_fall(n);
        checks++; if (n !== 4) begin errors++;
            $display("FAIL loss_hold_len got %0d want 4", n); end
        pll_locked = 1'b1;
        n = 0;
        while (sup_state !== 3'd4 && n < 100) begin
            step();
            n++;
        end
        checks++; if (sup_state !== 3'd4 || sup_locked !== 1'b1 || lock_loss_cnt !== 8'd1)
            begin errors++;
            $display("FAIL loss_relock got %0d/%b/%0d want 4/1/1", sup_state, sup_locked,
                     lock_loss_cnt); end
    endtask

    task automatic test_rst_mid_filter();
        int n;
        force_relock = 1'b1;
        step();
        force_relock = 1'b0;
        checks++; if (sup_state !== 3'd0 || ch_rst_n !== 4'b0000) begin errors++;
            $display("FAIL force_run got %0d/%b want 0/0000", sup_state, ch_rst_n); end
        n = 0;
        while (sup_state !== 3'd2 && n < 20) begin
            step();
            n++;
        end
        step_n(2);
        checks++; if (sup_state !== 3'd2) begin errors++;
            $display("FAIL arst_in_filter got %0d want 2", sup_state); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (sup_state !== 3'd0 || pll_rst !== 1'b1 || ch_rst_n !== 4'b0000)
            begin errors++;
            $display("FAIL arst_async got %0d/%b/%b want 0/1/0000", sup_state, pll_rst,
                     ch_rst_n); end
        checks++; if (lock_loss_cnt !== 8'd0 || sup_locked !== 1'b0) begin errors++;
            $display("FAIL arst_cnt got %0d/%b want 0/0", lock_loss_cnt, sup_locked); end
        #2;
        rst_n = 1'b1;
        wait_rst_fall(n);
        checks++; if (n !== 4) begin errors++;
            $display("FAIL arst_release got %0d want 4", n); end
    endtask

    task automatic test_glitch();
        int n;
        do_reset();
        wait_rst_fall(n);
        pll_locked = 1'b1;
        step_n(5);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step_n(2);
        checks++; if (sup_state !== 3'd1) begin errors++;
            $display("FAIL glitch_drop got %0d want 1", sup_state); end
        step();
        checks++; if (sup_state !== 3'd2) begin errors++;
            $display("FAIL glitch_reenter got %0d want 2", sup_state); end
        step_n(7);
        checks++; if (sup_state !== 3'd2 || ch_rst_n !== 4'b0000) begin errors++;
            $display("FAIL glitch_restart got %0d/%b want 2/0000", sup_state, ch_rst_n); end
        step();
        checks++; if (sup_state !== 3'd3 || ch_rst_n !== 4'b0001) begin errors++;
            $display("FAIL glitch_release got %0d/%b want 3/0001", sup_state, ch_rst_n); end
    endtask

    task automatic test_force_release();
        int n;
        do_reset();
        wait_rst_fall(n);
        pll_locked = 1'b1;
        step_n(13);
        checks++; if (sup_state !== 3'd3 || ch_rst_n !== 4'b0011) begin errors++;
            $display("FAIL force_pre got %0d/%b want 3/0011", sup_state, ch_rst_n); end
        force_relock = 1'b1;
        step();
        force_relock = 1'b0;
        checks++; if (sup_state !== 3'd0 || ch_rst_n !== 4'b0000 || pll_rst !== 1'b1)
            begin errors++;
            $display("FAIL force_release got %0d/%b/%b want 0/0000/1", sup_state, ch_rst_n,
                     pll_rst); end
    endtask

    task automatic test_timeout();
        logic prev;
        int   falls;
        int   first_rise;
        int   k;
        int   fail_seen;
        do_reset();
        prev       = 1'b1;
        falls      = 0;
        first_rise = -1;
        fail_seen  = 0;
        k          = 0;
`ifdef SOC_PLL_SUP_RETRY_LIMIT_EN
        while (failed !== 1'b1 && k < 400) begin
`else
        while (k < 390) begin
`endif
            step();
            k++;
            if (prev && !pll_rst) falls++;
            if (!prev && pll_rst && first_rise < 0) first_rise = k;
            if (failed) fail_seen++;
            prev = pll_rst;
        end
        checks++; if (first_rise !== 36) begin errors++;
            $display("FAIL timeout_first got %0d want 36", first_rise); end
`ifdef SOC_PLL_SUP_RETRY_LIMIT_EN
        checks++; if (k !== 108 || falls !== 3) begin errors++;
            $display("FAIL timeout_attempts got %0d/%0d want 108/3", k, falls); end
        checks++; if (sup_state !== 3'd5 || pll_rst !== 1'b1 || ch_rst_n !== 4'b0000)
            begin errors++;
            $display("FAIL timeout_failed got %0d/%b/%b want 5/1/0000", sup_state, pll_rst,
                     ch_rst_n); end
        step_n(20);
        checks++; if (failed !== 1'b1 || sup_state !== 3'd5) begin errors++;
            $display("FAIL failed_sticky got %b/%0d want 1/5", failed, sup_state); end
        force_relock = 1'b1;
        step();
        force_relock = 1'b0;
        checks++; if (failed !== 1'b0 || sup_state !== 3'd0) begin errors++;
            $display("FAIL failed_exit got %b/%0d want 0/0", failed, sup_state); end
`else
        checks++; if (falls !== 11) begin errors++;
            $display("FAIL timeout_attempts got %0d want 11", falls); end
        checks++; if (fail_seen !== 0 || sup_state === 3'd5) begin errors++;
            $display("FAIL timeout_no_fail got %0d/%0d want 0/not5", fail_seen, sup_state); end
`endif
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_lock_loss();
        test_rst_mid_filter();
        test_glitch();
        test_force_release();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/soc_pll_supervisor.md
# soc_pll_supervisor

Parametrised PLL lock supervisor placed next to the system PLL instance. It drives the PLL reset and qualifies the asynchronous `locked` output with a synchroniser, a stability filter and a timeout with retry. It releases NUM_CH downstream reset domains in a staggered sequence, and on loss of lock it re-asserts all of them and restarts the PLL. It runs entirely in the `refclk` domain.

## Interface
- NUM_CH, 4: number of downstream reset channels (1..16)
- RST_HOLD_CYCLES, 16: cycles `pll_rst` is held high per attempt (≥2)
- LOCK_FILTER_CYCLES, 1024: consecutive synchronised-high `locked` cycles required
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed from PLL reset release to filtered lock
- STAGGER_CYCLES, 8: spacing between successive channel releases (≥1)
- MAX_RETRIES, 3: failed attempts tolerated before FAILED (macro-dependent)

Ports:
- refclk  in  1  reference clock; the only clock
- rst_n  in  1  asynchronous assert, active-low reset
- pll_locked  in  1  PLL `locked`, asynchronous
- force_relock  in  1  single-cycle request to restart the PLL
- pll_rst  out  1  PLL reset, active-high
- ch_rst_n  out  NUM_CH  per-channel reset, active-low
- sup_locked  out  1  high only in RUN
- failed  out  1  high only in FAILED
- sup_state  out  3  current state encoding
- lock_loss_cnt  out  8  saturating count of lock losses seen in RELEASE/RUN

## Operation
- `pll_locked` passes through a 2-flop synchroniser (`lk_s`). All decisions use `lk_s`.
- States:
  - RESET_PLL=0: `pll_rst`=1. A hold counter runs RST_HOLD_CYCLES, then the block moves to WAIT_LOCK and clears the timeout counter.
  - WAIT_LOCK=1: `pll_rst`=0 and the timeout counter increments. `lk_s`=1 → FILTER with the filter counter cleared.
  - FILTER=2: the filter counter increments while `lk_s`=1. `lk_s`=0 → WAIT_LOCK; the timeout counter is not cleared. Count reaching LOCK_FILTER_CYCLES → RELEASE.
  - RELEASE=3: channel k is released at cycle k·STAGGER_CYCLES after entry, channel 0 first. When the last channel is released → RUN and `retry_cnt` is cleared.
  - RUN=4: all `ch_rst_n`=1 and `sup_locked`=1.
  - FAILED=5: `pll_rst`=1, all channels held in reset, `failed`=1.
- Timeout: if the timeout counter reaches LOCK_TIMEOUT_CYCLES in WAIT_LOCK or FILTER, `retry_cnt` increments and the block goes to RESET_PLL.
- Loss of lock: `lk_s`=0 in RELEASE or RUN sets all `ch_rst_n` to 0 on the next edge, increments `lock_loss_cnt` (saturating at 255) and goes to RESET_PLL. This is not counted as a retry.
- `force_relock`=1 in any state goes to RESET_PLL, clears `retry_cnt` and sets all `ch_rst_n` to 0. It takes precedence over every other transition in the same cycle.
- Counter widths are $clog2 of the parameter plus 1. Comparisons are exact equality.

## Timing
- Reset values:
  - `pll_rst`=1, `ch_rst_n`=0, `sup_locked`=0, `failed`=0
  - `sup_state`=0, `lock_loss_cnt`=0
  - synchroniser flops=0, all counters=0
- All outputs are registered, with no combinational path from input to output.
- `pll_rst` is high for exactly RST_HOLD_CYCLES cycles per attempt.
- Latency from a `pll_locked` rise to FILTER entry is 3 edges: 2 synchroniser edges plus 1 state edge.
- Latency from a `pll_locked` fall in RUN to `ch_rst_n`=0 is 3 edges.
- An `rst_n` assertion mid-sequence forces the reset values immediately, without waiting for a clock edge. Release happens on the first `refclk` edge with `rst_n`=1.

## Configuration
- SOC_PLL_SUP_RETRY_LIMIT_EN
  - Defined: when a timeout occurs with `retry_cnt`==MAX_RETRIES, the block goes to FAILED instead of RESET_PLL. FAILED is left only via `rst_n` or `force_relock`.
  - Undefined: the block retries forever, FAILED is unreachable, and `failed` is tied to 0.

## Structure
- Package `soc_pll_sup_pkg`: state enum and encodings, the `sup_state` width constant, and the `lock_loss_cnt` width/saturation constant.
- Sub-module `soc_pll_sup_sync`: the 2-flop synchroniser with asynchronous active-low reset. It is instantiated once.

## Test plan
Bench parameters: NUM_CH=4, RST_HOLD=4, FILTER=8, TIMEOUT=32, STAGGER=2, MAX_RETRIES=2.
- Clean lock: `pll_locked` rises 10 cycles after `pll_rst` falls → `pll_rst` high for 4 cycles, `ch_rst_n` steps 0001→0011→0111→1111 at 2-cycle spacing, then `sup_locked`=1.
- Glitchy lock: `locked` high for 5 cycles, low for 1, then stable → the filter restarts and RELEASE begins 8 `lk_s`-high cycles after the glitch.
- Loss of lock in RUN: drop `pll_locked` → 3 edges later `ch_rst_n`=0000, `lock_loss_cnt`=1, `pll_rst`=1. The block relocks normally afterwards.
- Timeout without a lock, macro defined → three RESET_PLL attempts, then `failed`=1 and `sup_state`=5. With the macro undefined → endless retries and `failed`=0.
- `force_relock` during RELEASE after 2 channels are released → next edge `ch_rst_n`=0000 and `sup_state`=0.
- `rst_n` pulsed low mid-FILTER → outputs return to reset values immediately, without waiting for a clock edge.
